// File: rtl/uart_port_responder.sv
// Bus-side UART model: CPU strobes on the low data byte, 8N1 receive buffer and transmit path.
// Latency: txd start bit 3 cycles after wrn rise is sampled; no backpressure, so writes are dropped while tbre=0.
module uart_port_responder #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       overrun,
  input  logic       rxd,
  output logic       txd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic rdn_q, rdn_d, wrn_q, wrn_d;
  logic rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rbr_q, rbr_d;
  logic data_ready_q, data_ready_d, overrun_q, overrun_d;
  tx_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] thr_q, thr_d, tsr_q, tsr_d;
  logic tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
  logic rd_done, wr_done, rx_commit;

  assign rdn_d     = rdn;
  assign wrn_d     = wrn;
  assign rx_meta_d = rxd;
  assign rx_s_d    = rx_meta_q;
  assign rd_done   = rdn & ~rdn_q;
  assign wr_done   = wrn & ~wrn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_q        <= 1'b1;
      wrn_q        <= 1'b1;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rbr_q        <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      thr_q        <= '0;
      tsr_q        <= '0;
      tbre_q       <= 1'b1;
      tsre_q       <= 1'b1;
      txd_q        <= 1'b1;
    end else begin
      rdn_q        <= rdn_d;
      wrn_q        <= wrn_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rbr_q        <= rbr_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      thr_q        <= thr_d;
      tsr_q        <= tsr_d;
      tbre_q       <= tbre_d;
      tsre_q       <= tsre_d;
      txd_q        <= txd_d;
    end
  end

  // Receive: start bit re-checked at mid-bit, then every sample lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_commit  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_commit  = rx_s_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A byte landing in the same cycle as a read wins, and is not an overrun.
  always_comb begin
    rbr_d        = rbr_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    if (rd_done) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (rx_commit) begin
      rbr_d        = rx_shift_q;
      data_ready_d = 1'b1;
      if (data_ready_q && !rd_done) overrun_d = 1'b1;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    thr_d      = thr_q;
    tsr_d      = tsr_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    txd_d      = 1'b1;
    if (wr_done && tbre_q) begin
      thr_d  = data_in;
      tbre_d = 1'b0;
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (!tbre_q) tx_state_d = TX_LOAD;
      end
      TX_LOAD: begin
        tsr_d      = thr_q;
        tbre_d     = 1'b1;
        tsre_d     = 1'b0;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        txd_d = tsr_q[0];
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          tsr_d    = {1'b0, tsr_q[7:1]};
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (!tbre_q) begin
            tx_state_d = TX_LOAD;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign data_out   = rbr_q;
  assign data_oe    = ~rdn & ~rst;
  assign data_ready = data_ready_q;
  assign overrun    = overrun_q;
  assign tbre       = tbre_q;
  assign tsre       = tsre_q;
  assign txd        = txd_q;

endmodule

// File: tb/tb_uart_port_responder.sv
// Scoreboard bench for uart_port_responder: random and directed RX/TX traffic against a byte-level model.
module tb_uart_port_responder;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdn = 1'b1;
  logic wrn = 1'b1;
  logic rxd = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic data_oe, data_ready, tbre, tsre, overrun, txd;

  uart_port_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rdn(rdn), .wrn(wrn), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .data_ready(data_ready),
    .tbre(tbre), .tsre(tsre), .overrun(overrun), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       rdy;
    logic       ovr;
  } rd_t;

  int errors = 0;
  int checks = 0;
  int tx_pushed = 0;
  int tx_seen = 0;
  logic [7:0] tx_exp[$];
  rd_t rd_exp[$];
  logic [7:0] m_rbr = 8'h00;
  logic m_ready = 1'b0;
  logic m_ovr = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
    if (stop) begin
      if (m_ready) m_ovr = 1'b1;
      m_rbr   = b;
      m_ready = 1'b1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in = b;
    wrn = 1'b0;
    tick(2);
    wrn = 1'b1;
  endtask

  task automatic expect_tx(input logic [7:0] b);
    tx_exp.push_back(b);
    tx_pushed++;
  endtask

  task automatic do_read();
    rd_t r;
    r.d = m_rbr;
    r.rdy = m_ready;
    r.ovr = m_ovr;
    rd_exp.push_back(r);
    rdn = 1'b0;
    tick(3);
    rdn = 1'b1;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rd_clears_ready", data_ready, m_ready);
    check("rd_clears_overrun", overrun, m_ovr);
    check("oe_released", data_oe, 1'b0);
    tick(1);
  endtask

  task automatic wait_tsre(input logic v, input int budget, input string nm);
    int n = 0;
    while (tsre !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, tsre, v);
  endtask

  task automatic wait_neg(input int n, output bit ab);
    ab = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  // Read monitor: compares the bus view on the first sampled cycle of each read.
  initial begin : rd_mon
    logic prev;
    rd_t r;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !rdn && !rst) begin
        check("rd_data_oe", data_oe, 1'b1);
        if (rd_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: read with no expectation, data_out 0x%0h", data_out);
        end else begin
          r = rd_exp.pop_front();
          check("rd_data_out", data_out, r.d);
          check("rd_data_ready", data_ready, r.rdy);
          check("rd_overrun", overrun, r.ovr);
        end
      end
      prev = rdn;
    end
  end

  // TX monitor: decodes txd at bit centres; a reset mid-frame abandons the frame.
  initial begin : tx_mon
    logic prev;
    logic [9:0] bits;
    bit ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !txd) begin
        ab = 1'b0;
        bits = '0;
        for (int s = 0; s < 10 && !ab; s++) begin
          wait_neg((s == 0) ? 7 : CPB, ab);
          bits[s] = txd;
        end
        if (!ab) begin
          tx_seen++;
          check("tx_start_bit", bits[0], 1'b0);
          check("tx_stop_bit", bits[9], 1'b1);
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: frame 0x%0h with nothing queued", bits[8:1]);
          end else begin
            check("tx_byte", bits[8:1], tx_exp.pop_front());
          end
        end
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, first_low, low_cnt, n;
    logic tb2, tb4;
    logic [7:0] rb, tb;

    // Reset and idle
    tick(3);
    check("rst_txd", txd, 1'b1);
    check("rst_tbre", tbre, 1'b1);
    check("rst_data_oe", data_oe, 1'b0);
    rst = 1'b0;
    tick(20);
    check("idle_txd", txd, 1'b1);
    check("idle_tbre", tbre, 1'b1);
    check("idle_tsre", tsre, 1'b1);
    check("idle_data_ready", data_ready, 1'b0);
    check("idle_overrun", overrun, 1'b0);
    check("idle_data_out", data_out, 8'h00);
    check("idle_data_oe", data_oe, 1'b0);

    // Receive 0xA5 and time data_ready from the start edge
    lat = 0;
    fork
      send_rx(8'hA5, 1'b1);
      begin
        while (!data_ready && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("rx_latency_window", (lat >= 145 && lat <= 165), 1'b1);
    tick(2);
    do_read();

    // Single write: tbre/tsre/txd timing
    expect_tx(8'h3C);
    write_byte(8'h3C);
    first_low = 0;
    low_cnt = 0;
    tb2 = 1'b1;
    tb4 = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 2) tb2 = tbre;
      if (i == 4) tb4 = tbre;
      if (!txd && first_low == 0) first_low = i;
      if (!tsre) low_cnt++;
    end
    check("wr_tbre_low", tb2, 1'b0);
    check("load_tbre_high", tb4, 1'b1);
    check("tx_start_latency", first_low, 5);
    check("tx_tsre_low_cycles", low_cnt, 10 * CPB);
    tick(1);

    // Back-to-back frames; third write while holding register full is dropped
    low_cnt = 0;
    expect_tx(8'h11);
    expect_tx(8'h22);
    fork
      begin
        n = 0;
        while (tsre && n < 50) begin
          @(negedge clk);
          n++;
        end
        while (!tsre && low_cnt < 1000) begin
          @(negedge clk);
          low_cnt++;
        end
      end
      begin
        write_byte(8'h11);
        n = 0;
        while (tbre !== 1'b1 || tsre !== 1'b0) begin
          if (n > 50) break;
          @(negedge clk);
          n++;
        end
        tick(1);
        write_byte(8'h22);
        tick(2);
        check("b2b_tbre_full", tbre, 1'b0);
        write_byte(8'h33);
      end
    join
    // One LOAD cycle separates the two frames.
    check("b2b_tsre_low_window", (low_cnt >= 20 * CPB && low_cnt <= 20 * CPB + 1), 1'b1);
    tick(20);

    // Overrun, read clears, then framing error
    send_rx(8'h01, 1'b1);
    send_rx(8'h02, 1'b1);
    tick(5);
    check("ovr_flag_set", overrun, 1'b1);
    do_read();
    send_rx(8'h5A, 1'b0);
    tick(30);
    check("frame_err_no_ready", data_ready, m_ready);
    check("frame_err_keeps_rbr", data_out, m_rbr);

    // Randomised concurrent RX and TX traffic
    for (int it = 0; it < 6; it++) begin
      rb = 8'($urandom);
      tb = 8'($urandom);
      expect_tx(tb);
      fork
        send_rx(rb, 1'b1);
        begin
          tick($urandom_range(1, 20));
          write_byte(tb);
        end
      join
      tick(3);
      do_read();
      wait_tsre(1'b1, 400, "rand_tsre_idle");
      tick($urandom_range(1, 10));
    end

    // Reset during bit 4 of a transmission
    write_byte(8'hC3);
    tick(3 + CPB * 5 + CPB / 2);
    check("pre_rst_tsre_busy", tsre, 1'b0);
    rdn = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_tsre", tsre, 1'b1);
    check("mid_rst_tbre", tbre, 1'b1);
    check("mid_rst_data_oe", data_oe, 1'b0);
    tick(2);
    rdn = 1'b1;
    tick(1);
    rst = 1'b0;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    m_rbr = 8'h00;
    tx_exp.delete();
    tick(2);
    expect_tx(8'h96);
    write_byte(8'h96);
    wait_tsre(1'b0, 20, "post_rst_tx_start");
    wait_tsre(1'b1, 400, "post_rst_tx_done");
    tick(20);

    check("tx_queue_drained", tx_exp.size(), 0);
    check("rd_queue_drained", rd_exp.size(), 0);
    check("tx_frame_count", tx_seen, tx_pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
